// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU/MTHI/MTLO); optional MULDIV_FAST_MULT_EN.
// Latency: mul/div busy WIDTH+1 cycles, done pulses the following cycle; MTHI/MTLO and fast multiplies write at the start edge.
// Backpressure: start is ignored while busy=1; the issuer holds its instruction until busy drops (done cycle accepts a new start).

typedef logic [5:0] funct_t;

module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  funct_t           fncode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam funct_t FUNCT_MTHI  = 6'h11;
    localparam funct_t FUNCT_MTLO  = 6'h13;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;
    localparam int     CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;   // partial product high half / running remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0] md;       // multiplicand or divisor magnitude
    logic             op_div;
    logic             neg_hi;   // remainder takes the dividend sign
    logic             neg_lo;   // product / quotient sign
    logic             div0;

    logic is_mul, is_div, is_signed, is_mthi, is_mtlo, iter_op;

    // Decode the requested operation; unknown codes decode to nothing.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (fncode)
            FUNCT_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            FUNCT_MULTU: is_mul = 1'b1;
            FUNCT_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            FUNCT_DIVU:  is_div = 1'b1;
            FUNCT_MTHI:  is_mthi = 1'b1;
            FUNCT_MTLO:  is_mtlo = 1'b1;
            default:     ;
        endcase
    end

    // Operand magnitudes; the most negative value maps onto itself, which is the right unsigned magnitude.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // One shift-add or restoring shift-subtract step on the working registers.
    logic [WIDTH:0] mul_sum, div_shift, div_trial;
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, md};
    end

    // Sign correction for write-back. With a zero divisor the restoring loop already leaves |a|
    // as remainder, so only the quotient needs overriding; signed overflow falls out naturally.
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_mag = {acc_hi, acc_lo};
    assign prod_fix = neg_lo ? -prod_mag : prod_mag;
    assign quo_fix  = div0 ? {WIDTH{1'b1}} : (neg_lo ? -acc_lo : acc_lo);
    assign rem_fix  = neg_hi ? -acc_hi : acc_hi;

`ifdef MULDIV_FAST_MULT_EN
    // Low 2*WIDTH bits of a product are the same for signed and unsigned once operands are extended.
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign ext_b     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign fast_prod = ext_a * ext_b;
    assign iter_op   = is_div;
`else
    assign iter_op   = is_mul | is_div;
`endif

    // Control FSM and all architectural/working state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            md     <= '0;
            op_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (iter_op) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            op_div <= is_div;
                            div0   <= is_div && (b == '0);
                            neg_hi <= is_signed & a[WIDTH-1];
                            neg_lo <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            acc_hi <= '0;
                            acc_lo <= is_div ? a_mag : b_mag;
                            md     <= is_div ? b_mag : a_mag;
                        end
`ifdef MULDIV_FAST_MULT_EN
                        else if (is_mul) begin
                            hi   <= fast_prod[2*WIDTH-1:WIDTH];
                            lo   <= fast_prod[WIDTH-1:0];
                            done <= 1'b1;
                        end
`endif
                        else if (is_mthi) begin
                            hi <= a;
                        end else if (is_mtlo) begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (op_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed vectors for mips_muldiv checked against a cycle-level arithmetic model.
// Latency: the model predicts busy/done/hi/lo every cycle; literal expectations pin key results.
// Backpressure: the bench issues start only when the model says the unit is idle, except the deliberate busy-start case.
module tb_mips_muldiv;
    localparam int W = 32;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         start  = 1'b0;
    logic [5:0]   fncode = 6'h3F;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fncode (fncode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} of a mul/div, straight from integer arithmetic.
    function automatic logic [63:0] calc(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sp;
        int xs, ys;
        xs = x;
        ys = y;
        case (op)
            OP_MULT: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_DIV: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, x};
                return {32'(xs % ys), 32'(xs / ys)};
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Timing model: an accepted mul/div occupies the unit for W+1 cycles, then results land with a done pulse.
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int           m_cnt;
    bit           m_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (fncode inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
                    if (FAST && (fncode == OP_MULT || fncode == OP_MULTU)) begin
                        {m_hi, m_lo} <= calc(fncode, a, b);
                        m_done       <= 1'b1;
                    end else begin
                        {p_hi, p_lo} <= calc(fncode, a, b);
                        m_cnt        <= W + 1;
                    end
                end else if (fncode == OP_MTHI) begin
                    m_hi <= a;
                end else if (fncode == OP_MTLO) begin
                    m_lo <= a;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", W'(busy), W'(m_cnt != 0));
            check("cyc_done", W'(done), W'(m_done));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_busy_done_excl", W'(busy & done), '0);
        end
    end

    // Present one start cycle, then scramble operands to show they are only needed at acceptance.
    task automatic drive(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start  = 1'b1;
        fncode = op;
        a      = x;
        b      = y;
        @(negedge clk);
        start  = 1'b0;
        fncode = 6'h3F;
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit got;
        got = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, W'(got), W'(1));
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int bc;
        @(negedge clk);
        drive(op, x, y);
        wait_done(name, bc);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_busy_cycles"}, W'(bc),
              (FAST && (op == OP_MULT || op == OP_MULTU)) ? W'(0) : W'(33));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        check("multu_max_single_done", W'(done), '0);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_negneg", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'd15);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negdivisor", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_zero", OP_DIV, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // MTLO writes immediately with no busy, then a start during a divide must be ignored.
        @(negedge clk);
        drive(OP_MTLO, 32'h12345678, 32'h0);
        check("mtlo_lo", lo, 32'h12345678);
        check("mtlo_busy", W'(busy), '0);
        drive(OP_DIVU, 32'd9, 32'd4);
        repeat (3) @(negedge clk);
        drive(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_ignored_hold", hi, '0);
        wait_done("divu_9_4", bc);
        check("divu_9_4_hi", hi, 32'd1);
        check("divu_9_4_lo", lo, 32'd2);

        // Back-to-back: second multiply issued in the done cycle of the first.
        @(negedge clk);
        drive(OP_MULTU, 32'd5, 32'd5);
        wait_done("b2b_first", bc);
        check("b2b_first_lo", lo, 32'd25);
        drive(OP_MULTU, 32'd6, 32'd7);
        check("b2b_hold_lo", lo, FAST ? 32'd42 : 32'd25);
        wait_done("b2b_second", bc);
        check("b2b_second_lo", lo, 32'd42);
        check("b2b_second_hi", hi, 32'd0);

        // Asynchronous reset in the middle of an iterative operation.
        @(negedge clk);
        drive(OP_DIVU, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", W'(busy), '0);
        check("midrst_done", W'(done), '0);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_multu", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit owning the HI/LO register pair; the multi-cycle companion to the single-cycle ALU in the MIPS CPU datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake, and exposes HI/LO continuously for MFHI/MFLO. Operand width is parametrised; the core uses 32.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- fncode  in  funct_t  operation: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO; any other value with start is a no-op.
- a  in  WIDTH  rs operand: multiplicand / dividend / MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier / divisor.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN (WIDTH iterations), FIX (sign correction and write-back).
- IDLE + start + mul/div op:
  - Latch operands as magnitudes; signed ops use two's-complement absolute values and record the result signs.
  - Clear the iteration counter and enter RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Go to FIX after WIDTH steps.
- FIX:
  - Apply signs.
  - Write HI/LO, assert done next cycle, return to IDLE.
- Multiply: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
- Divide: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Divide by zero (signed or unsigned): lo = all ones, hi = a.
- Signed overflow (a = most negative, b = -1): lo = a, hi = 0.
- MTHI/MTLO with start in IDLE: hi (resp. lo) = a at that edge. No busy, no done.
- start while busy=1: ignored; the operation in flight is unaffected.
- hi/lo hold previous values throughout RUN/FIX; partial results are never visible.
- Reset (any time, including mid-operation):
  - State returns to IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Counter and operand registers cleared.

## Timing
- Mul/div accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
  - hi/lo written at edge k+WIDTH+1.
  - done=1 for exactly the cycle following that edge.
- busy is registered; it equals (state != IDLE).
- done and busy are never both 1.
- A new start is accepted in the cycle done=1, giving back-to-back operations with no gap.
- MTHI/MTLO accepted at edge k: hi/lo reflects the new value immediately after edge k.
- Inputs a, b and fncode need only be valid in the start cycle.

## Configuration
- MULDIV_FAST_MULT_EN defined:
  - MULT/MULTU complete in one cycle using a combinational WIDTH x WIDTH multiply.
  - Start at edge k writes hi/lo at edge k; done=1 the following cycle; busy stays 0.
  - Divides are unchanged.
- Not defined: multiplies use the iterative WIDTH+1-cycle path described above.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high 33 cycles, single done pulse; with MULDIV_FAST_MULT_EN, done one cycle after start and busy never high.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO a=0x12345678 in IDLE -> lo=0x12345678 next cycle. Then start DIVU 9/4, and assert start+MTHI while busy -> MTHI ignored; final hi=1, lo=2.
- Back-to-back: assert start with MULTU 6*7 in the done cycle of the previous op -> accepted; result lo=42, hi=0; hi/lo hold old values until the new done.
- Drop rst_n at RUN iteration 10 -> busy, done, hi, lo all 0 immediately. After release, MULTU 3*4 -> lo=12 with normal latency.
